// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB completer memory block.
package apb_completer_pkg;

    // Width of the wait-state counter; holds wait counts 0..15.
    localparam int CNT_W = 4;

    // Widest PRDATA the response record can carry.
    localparam int MAX_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Response presented to the requester during the access phase.
    typedef struct packed {
        logic                  ready;
        logic                  slverr;
        logic [MAX_DATA_W-1:0] rdata;
    } resp_t;

endpackage

// File: rtl/apb_completer_regfile.sv
// Byte-wide register storage: asynchronous clear, one synchronous write
// port and one combinational read port.
module apb_completer_regfile
    import apb_completer_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              rd_in_range;

    // Storage update: whole array clears on reset, one location per write.
    // NOTE: this array has a reset, so it maps to flops rather than a RAM
    // macro; it is needed because every location must read 0 after reset.
    // NOTE: sequential state uses <= so all flops sample the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Guard against indexing past DEPTH when it is not a power of two.
    assign rd_in_range = ({1'b0, rd_addr_i} < (AW + 1)'(DEPTH));
    assign rd_data_o   = rd_in_range ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer with a small register memory, programmable wait states and
// PSLVERR for out-of-range, misdirected and unstable transfers.
module apb_completer_mem
    import apb_completer_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int SLAVE_ID    = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W  = ADDR_W - 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               viol_q, viol_d;

    logic [IDX_W-1:0]   idx;
    logic               sel_ok;
    logic               range_ok;
    logic               err;
    logic               ready;
    logic               mismatch;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;
    resp_t              resp;

    // Everything about the response is decoded from latched state only.
    assign idx      = addr_q[IDX_W-1:0];
    assign sel_ok   = (addr_q[ADDR_W-1] == 1'(SLAVE_ID));
    assign range_ok = ({1'b0, idx} < (IDX_W + 1)'(DEPTH));
    assign err      = !sel_ok || !range_ok || viol_q;
    assign ready    = (state_q == ACCESS) && (cnt_q == '0);

    // The requester must hold address, direction and write data steady
    // through the access phase.
    assign mismatch = (PADDR != addr_q) || (PWRITE != write_q) ||
                      (write_q && (PWDATA != wdata_q));

    // Next-state, counter, capture and write-enable decode.
    // NOTE: every signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        viol_d  = viol_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a proper setup phase starts a transfer; PSEL with
                // PENABLE already high is ignored.
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    viol_d  = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    // Requester walked away: abandon without side effects.
                    state_d = IDLE;
                end else if (ready) begin
                    // Completion edge. A change seen only here cannot alter
                    // the response already presented, so the flag as it
                    // stands decides both PSLVERR and the write.
                    state_d = IDLE;
                    mem_we  = write_q && !err;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    viol_d = viol_q || mismatch;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counter and transfer-capture registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            viol_q  <= viol_d;
        end
    end

    apb_completer_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_regfile (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .wr_en_i   (mem_we),
        .wr_addr_i (idx[MEM_AW-1:0]),
        .wr_data_i (wdata_q),
        .rd_addr_i (idx[MEM_AW-1:0]),
        .rd_data_o (mem_rdata)
    );

    // Response build: read data only on a good read completion, else zero.
    always_comb begin
        resp        = '0;
        resp.ready  = ready;
        resp.slverr = ready && err;
        if (ready && !write_q && !err) begin
            resp.rdata = MAX_DATA_W'(mem_rdata);
        end
    end

    assign PREADY  = resp.ready;
    assign PSLVERR = resp.slverr;
    assign PRDATA  = DATA_W'(resp.rdata);

endmodule

// File: tb/tb_apb_completer_mem.sv
// Self-checking bench for apb_completer_mem: three instances with different
// wait counts, depths and slave IDs, directed scenarios plus random traffic
// checked against a memory-array reference model.
module tb_apb_completer_mem;

    localparam int NINST = 3;

    logic                clk = 1'b0;
    logic                preset;
    logic [NINST-1:0]    psel;
    logic                penable;
    logic                pwrite;
    logic [8:0]          paddr;
    logic [7:0]          pwdata;
    logic [NINST-1:0]    pready;
    logic [NINST-1:0]    pslverr;
    logic [7:0]          prdata [NINST];

    int errors = 0;
    int checks = 0;

    // Reference memory contents per instance.
    logic [7:0] mem_m [NINST][256];

    always #5 clk = ~clk;

    // Instance 0: one wait state, full depth, slave 0.
    apb_completer_mem #(
        .ADDR_W(9), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(1), .SLAVE_ID(0)
    ) dut_a (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    // Instance 1: zero wait, 16 locations, slave 0.
    apb_completer_mem #(
        .ADDR_W(9), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0), .SLAVE_ID(0)
    ) dut_b (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    // Instance 2: three wait states, 200 locations, slave 1.
    apb_completer_mem #(
        .ADDR_W(9), .DATA_W(8), .DEPTH(200), .WAIT_CYCLES(3), .SLAVE_ID(1)
    ) dut_c (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    function automatic int inst_wait(input int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int inst_depth(input int i);
        case (i)
            0: return 256;
            1: return 16;
            default: return 200;
        endcase
    endfunction

    function automatic int inst_id(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NINST; i++)
            for (int j = 0; j < 256; j++)
                mem_m[i][j] = 8'h00;
    endtask

    // Reference rules: error if wrong slave bit, index beyond depth, or an
    // unstable access phase; errors suppress writes and read as zero.
    task automatic model_xfer(input int inst, input bit wr, input logic [8:0] addr,
                              input logic [7:0] wdata, input bit viol,
                              output logic [7:0] exp_rdata, output logic exp_err);
        int idx;
        idx       = int'(addr[7:0]);
        exp_err   = (int'(addr[8]) != inst_id(inst)) || (idx >= inst_depth(inst)) || viol;
        exp_rdata = 8'h00;
        if (!exp_err) begin
            if (wr) mem_m[inst][idx] = wdata;
            else    exp_rdata = mem_m[inst][idx];
        end
    endtask

    // Drive one transfer starting at posedge+1; ends at posedge+1 after the
    // completion edge with PSEL/PENABLE still high, so a following call
    // forms a back-to-back transfer.
    task automatic apb_xfer(input int inst, input bit wr, input logic [8:0] addr,
                            input logic [7:0] wdata, input bit corrupt,
                            output logic [7:0] rdata, output logic slverr,
                            output int waits);
        bit done;
        rdata   = 8'h00;
        slverr  = 1'b0;
        waits   = 0;
        done    = 1'b0;
        psel    = '0;
        psel[inst] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pready[inst]) begin
                rdata  = prdata[inst];
                slverr = pslverr[inst];
                done   = 1'b1;
            end else begin
                waits++;
                if (corrupt && waits == 1) paddr = addr ^ 9'h001;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d addr=%h: PREADY never rose within 40 cycles", inst, addr);
        end
    endtask

    task automatic run_xfer(input int inst, input bit wr, input logic [8:0] addr,
                            input logic [7:0] wdata, input bit corrupt,
                            output bit ok, output string detail);
        logic [7:0] rd, exp_rd;
        logic       err, exp_err;
        int         waits, exp_waits;
        apb_xfer(inst, wr, addr, wdata, corrupt, rd, err, waits);
        exp_waits = inst_wait(inst);
        model_xfer(inst, wr, addr, wdata, corrupt && (exp_waits > 0), exp_rd, exp_err);
        ok = (waits == exp_waits) && (err === exp_err) && (rd === exp_rd);
        detail = $sformatf("dut%0d %s addr=%h: got waits=%0d err=%b rdata=%h, expected waits=%0d err=%b rdata=%h",
                           inst, wr ? "wr" : "rd", addr, waits, err, rd, exp_waits, exp_err, exp_rd);
    endtask

    task automatic bus_idle();
        psel    = '0;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit ok; string d;
        #3;
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if ({pready[i], pslverr[i], prdata[i]} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got ready=%b err=%b rdata=%h, expected all 0",
                         i, pready[i], pslverr[i], prdata[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(posedge clk); #1;
        run_xfer(0, 1'b0, 9'h005, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL reset_read: %s", d); end
        bus_idle();
    endtask

    task automatic test_write_read();
        bit ok; string d;
        run_xfer(0, 1'b1, 9'h010, 8'hA5, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL write_a5: %s", d); end
        run_xfer(0, 1'b0, 9'h010, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL readback_a5: %s", d); end
        bus_idle();
    endtask

    task automatic test_misdirected();
        bit ok; string d;
        run_xfer(0, 1'b1, 9'h110, 8'h3C, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL misdirected_write: %s", d); end
        run_xfer(0, 1'b0, 9'h010, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL misdirected_keep: %s", d); end
        bus_idle();
    endtask

    task automatic test_stability();
        bit ok; string d;
        run_xfer(0, 1'b1, 9'h020, 8'h5A, 1'b1, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL stability_write: %s", d); end
        bus_idle();
        run_xfer(0, 1'b0, 9'h020, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL stability_read20: %s", d); end
        run_xfer(0, 1'b0, 9'h021, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL stability_read21: %s", d); end
        bus_idle();
    endtask

    task automatic test_no_setup();
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 9'h010;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (pready[0] !== 1'b0) begin
                errors++;
                $display("FAIL no_setup cycle %0d: got PREADY=%b, expected 0", c, pready[0]);
            end
        end
        bus_idle();
    endtask

    task automatic test_abort();
        bit ok; string d;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 9'h030; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        checks++;
        if (pready[0] !== 1'b0) begin errors++; $display("FAIL abort_wait: got PREADY=%b, expected 0", pready[0]); end
        penable = 1'b0;
        @(posedge clk); #1;
        psel = '0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (pready[0] !== 1'b0) begin errors++; $display("FAIL abort_idle %0d: got PREADY=%b, expected 0", c, pready[0]); end
            @(posedge clk); #1;
        end
        run_xfer(0, 1'b0, 9'h030, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL abort_read: %s", d); end
        bus_idle();
    endtask

    task automatic test_reset_abort();
        bit ok; string d;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 9'h030; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        model_clear();
        #2;
        checks++;
        if ({pready[0], pslverr[0], prdata[0]} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got ready=%b err=%b rdata=%h, expected all 0",
                     pready[0], pslverr[0], prdata[0]);
        end
        #1 preset = 1'b0;
        @(posedge clk); #1;
        run_xfer(0, 1'b0, 9'h030, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL reset_abort_read30: %s", d); end
        run_xfer(0, 1'b0, 9'h010, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL reset_cleared10: %s", d); end
        bus_idle();
    endtask

    task automatic test_zero_wait_range();
        bit ok; string d;
        run_xfer(1, 1'b0, 9'h00F, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL zw_read_0f: %s", d); end
        run_xfer(1, 1'b0, 9'h010, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL range_read_10: %s", d); end
        run_xfer(1, 1'b1, 9'h010, 8'hEE, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL range_write_10: %s", d); end
        run_xfer(1, 1'b0, 9'h000, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL range_alias_00: %s", d); end
        run_xfer(1, 1'b1, 9'h00F, 8'hC3, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL zw_write_0f: %s", d); end
        run_xfer(1, 1'b0, 9'h00F, 8'h00, 1'b0, ok, d);
        checks++; if (!ok) begin errors++; $display("FAIL zw_readback_0f: %s", d); end
        bus_idle();
    endtask

    task automatic test_random();
        bit ok; string d;
        int inst;
        bit wr, corrupt;
        logic [8:0] addr;
        for (int n = 0; n < 150; n++) begin
            inst = int'($urandom_range(0, NINST - 1));
            wr   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    addr = {1'(inst_id(inst)), 8'($urandom_range(0, 15))};
                2:       addr = {1'(inst_id(inst)), 8'($urandom_range(0, 255))};
                default: addr = 9'($urandom_range(0, 511));
            endcase
            corrupt = ($urandom_range(0, 5) == 0);
            run_xfer(inst, wr, addr, 8'($urandom_range(0, 255)), corrupt, ok, d);
            checks++; if (!ok) begin errors++; $display("FAIL random_%0d: %s", n, d); end
            if ($urandom_range(0, 2) == 0) bus_idle();
        end
        bus_idle();
    endtask

    initial begin
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_clear();
        test_reset();
        test_write_read();
        test_misdirected();
        test_stability();
        test_no_setup();
        test_abort();
        test_reset_abort();
        test_zero_wait_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_completer_mem.md
Name: apb_completer_mem

Overview:
- APB completer (slave) that answers the transfers our APB requester drives.
- Holds a small byte-wide register memory and inserts a programmable number of wait states.
- Flags out-of-range accesses, misdirected accesses and mid-transfer protocol violations on PSLVERR.
- Sits behind the requester's PSEL/PENABLE outputs. One instance per slave slot, selected by PADDR[8].

Parameters:
- ADDR_W, 9: PADDR width. Bit ADDR_W-1 is the slave-select bit.
- DATA_W, 8: PWDATA/PRDATA width.
- DEPTH, 256: implemented locations, indexed by PADDR[ADDR_W-2:0]. Must be at most 2^(ADDR_W-1).
- WAIT_CYCLES, 1: wait states inserted per transfer, range 0..15. 0 means a zero-wait completer.
- SLAVE_ID, 0: required value of PADDR[ADDR_W-1].

Ports:
- PCLK  in  1  clock; all state changes on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  transfer address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - FSM goes to IDLE; wait counter clears.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All memory locations clear to 0.
  - Reset asserted mid-transfer aborts the transfer; no write is committed.
- FSM states: IDLE and ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 at a clock edge: latch PADDR, PWRITE and PWDATA; load the counter with WAIT_CYCLES; go to ACCESS.
  - PSEL=1 with PENABLE=1 in IDLE (no setup phase) is ignored and produces no response.
- ACCESS:
  - PREADY = (counter == 0). It is a registered-state decode and does not depend on the current inputs.
  - While counter != 0, decrement by 1 per cycle and hold PREADY=0.
  - Latency from the setup-phase edge to PREADY=1 is exactly WAIT_CYCLES cycles into the access phase. WAIT_CYCLES=0 gives PREADY=1 in the first access cycle.
  - If PSEL=0 or PENABLE=0 at any edge while in ACCESS: abort, return to IDLE, commit no write.
  - Stability check: if PADDR, PWRITE or (on a write) PWDATA differ from the latched values at any access-phase edge, set a sticky violation flag.
  - Completion edge (PREADY=1 with PSEL=1 and PENABLE=1): return to IDLE. Back-to-back transfers work because the next setup phase is captured from IDLE on the following edge.
- Error conditions, evaluated on the latched values: latched address index >= DEPTH, latched PADDR[ADDR_W-1] != SLAVE_ID, or violation flag set.
- Error response:
  - PSLVERR=1 together with PREADY=1.
  - A write is suppressed (memory unchanged). A read returns PRDATA=0.
- Good response:
  - Write: mem[index] <= latched PWDATA on the completion edge.
  - Read: PRDATA = mem[index] combinationally while PREADY=1.
- Output idle values:
  - PRDATA=0 whenever PREADY=0 or on a write completion.
  - PSLVERR=0 whenever PREADY=0.
- A read of a location written in the previous transfer returns the new data.

Decomposition:
- Package apb_completer_pkg:
  - state enum {IDLE, ACCESS};
  - counter width constant CNT_W=4;
  - response typedef {ready, slverr, rdata}.
- Sub-module apb_completer_regfile: DEPTH x DATA_W storage with asynchronous clear, one write port and one combinational read port.
- The FSM, counter and checks stay in the top module.

Test Plan:
- Reset then read: assert PRESET, release, read 0x005 with WAIT_CYCLES=1 -> PREADY high on the 2nd access cycle, PRDATA=0x00, PSLVERR=0.
- Write then read: write 0xA5 to 0x010, then read 0x010 back-to-back -> each transfer has exactly one wait cycle, PRDATA=0xA5, PSLVERR=0.
- Misdirected write: write 0x3C to 0x110 (PADDR[8]=1, SLAVE_ID=0) -> PSLVERR=1 with PREADY; a later read of 0x010 still returns 0xA5.
- Stability violation: start a write to 0x020, change PADDR to 0x021 during the wait cycle -> PSLVERR=1 at completion, 0x020 and 0x021 both read 0x00.
- Abort: drop PENABLE during the wait state of a write of 0x77 to 0x030 -> no PREADY, FSM in IDLE, read 0x030 returns 0x00. Repeat with PRESET pulsed mid-transfer -> same result.
- Zero-wait and range: with WAIT_CYCLES=0 and DEPTH=16, read 0x00F -> PREADY in the first access cycle, PSLVERR=0. Read 0x010 -> PSLVERR=1, PRDATA=0.
